// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 scancode FIFO: ZX-Uno register addresses,
// KBSTATUS bit positions, FIFO entry layout and the flush control bit.
`timescale 1ns/1ps
package ps2_pkg;
    localparam logic [7:0] ADDR_SCANCODE = 8'h04;
    localparam logic [7:0] ADDR_KBSTATUS = 8'h05;

    localparam int KB_BSY  = 7;
    localparam int KB_OVF  = 6;
    localparam int KB_FULL = 5;
    localparam int KB_ERR  = 3;
    localparam int KB_RLS  = 2;
    localparam int KB_EXT  = 1;
    localparam int KB_PEN  = 0;

    localparam int ENT_RLS   = 9;
    localparam int ENT_EXT   = 8;
    localparam int ENT_W     = 10;
    localparam int FLUSH_BIT = 7;

    typedef struct packed {
        logic       rls;
        logic       ext;
        logic [7:0] code;
    } entry_t;

    function automatic entry_t make_entry(input logic rls, input logic ext, input logic [7:0] code);
        entry_t e;
        e.rls  = rls;
        e.ext  = ext;
        e.code = code;
        return e;
    endfunction
endpackage

// File: rtl/sync_fifo_core.sv
// Generic single-clock FIFO; the head output is registered from next-state
// so it is valid one cycle after the push/pop/flush that changed it.
`timescale 1ns/1ps
module sync_fifo_core #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty,
    output logic             dropped
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic [WIDTH-1:0] head_reg;
    logic             do_push, do_pop;

    assign full  = (count_reg == (AW+1)'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign head  = head_reg;

    always_comb begin
        do_pop      = pop && !empty && !flush;
        do_push     = push && (!full || do_pop) && !flush;
        dropped     = push && full && !do_pop && !flush;
        rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
        count_next  = count_reg;
        if (do_push && !do_pop)
            count_next = count_reg + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_next = count_reg - (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            // A write landing on the new head slot bypasses the array read.
            if (do_push && (wr_ptr_reg == rd_ptr_next))
                head_reg <= din;
            else
                head_reg <= mem[rd_ptr_next];
        end
    end
endmodule

// File: rtl/ps2_scancode_fifo.sv
// PS/2 scancode FIFO behind the ZX-Uno SCANCODE/KBSTATUS registers.
// Define PS2_FIFO_IRQ_EN to build the occupancy/overflow interrupt.
`timescale 1ns/1ps
module ps2_scancode_fifo
    import ps2_pkg::*;
#(
    parameter int         DEPTH     = 16,
    parameter int         AW        = 4,
    parameter logic [7:0] SCANCODE  = ADDR_SCANCODE,
    parameter logic [7:0] KBSTATUS  = ADDR_KBSTATUS,
    parameter int         IRQ_LEVEL = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_received,
    input  logic [7:0] scancode,
    input  logic       extended,
    input  logic       released,
    input  logic       ps2busy,
    input  logic       kberror,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] scancode_dout,
    output logic       oe_n_scancode,
    output logic [7:0] kbstatus_dout,
    output logic       oe_n_kbstatus,
    output logic       fifo_irq
);
    logic       rd_sc, rd_ks, sc_fall, ks_fall, flush;
    logic       rd_sc_prev_reg, rd_ks_prev_reg;
    logic       bsy_reg, err_reg, ovf_reg;
    logic       full, empty, dropped;
    logic [AW:0] count;
    entry_t     head;

    assign rd_sc   = zxuno_regrd && (zxuno_addr == SCANCODE);
    assign rd_ks   = zxuno_regrd && (zxuno_addr == KBSTATUS);
    assign sc_fall = rd_sc_prev_reg && !rd_sc;
    assign ks_fall = rd_ks_prev_reg && !rd_ks;
    assign flush   = zxuno_regwr && (zxuno_addr == KBSTATUS) && din[FLUSH_BIT];

    assign oe_n_scancode = ~rd_sc;
    assign oe_n_kbstatus = ~rd_ks;

    sync_fifo_core #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_core (
        .clk     (clk),
        .srst    (rst),
        .push    (scan_received),
        .pop     (sc_fall),
        .flush   (flush),
        .din     (make_entry(released, extended, scancode)),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .dropped (dropped)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sc_prev_reg <= 1'b0;
            rd_ks_prev_reg <= 1'b0;
            bsy_reg        <= 1'b0;
            err_reg        <= 1'b0;
            ovf_reg        <= 1'b0;
        end else begin
            rd_sc_prev_reg <= rd_sc;
            rd_ks_prev_reg <= rd_ks;
            bsy_reg        <= ps2busy;
            err_reg        <= kberror;
            // A drop in the same cycle as a status-read edge keeps OVF set.
            if (flush)
                ovf_reg <= 1'b0;
            else if (dropped)
                ovf_reg <= 1'b1;
            else if (ks_fall)
                ovf_reg <= 1'b0;
        end
    end

    assign scancode_dout = empty ? 8'h00 : head.code;

    always_comb begin
        kbstatus_dout          = 8'h00;
        kbstatus_dout[KB_BSY]  = bsy_reg;
        kbstatus_dout[KB_OVF]  = ovf_reg;
        kbstatus_dout[KB_FULL] = full;
        kbstatus_dout[KB_ERR]  = err_reg;
        kbstatus_dout[KB_RLS]  = !empty && head.rls;
        kbstatus_dout[KB_EXT]  = !empty && head.ext;
        kbstatus_dout[KB_PEN]  = !empty;
    end

`ifdef PS2_FIFO_IRQ_EN
    logic irq_reg;
    always_ff @(posedge clk) begin
        if (rst)
            irq_reg <= 1'b0;
        else
            irq_reg <= (count >= (AW+1)'(IRQ_LEVEL)) || ovf_reg;
    end
    assign fifo_irq = irq_reg;
`else
    assign fifo_irq = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_ps2_scancode_fifo;
    localparam int DEPTH     = 16;
    localparam int IRQ_LEVEL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_received = 1'b0;
    logic [7:0] scancode = 8'h00;
    logic       extended = 1'b0;
    logic       released = 1'b0;
    logic       ps2busy = 1'b0;
    logic       kberror = 1'b0;
    logic [7:0] zxuno_addr = 8'h00;
    logic       zxuno_regrd = 1'b0;
    logic       zxuno_regwr = 1'b0;
    logic [7:0] din = 8'h00;
    logic [7:0] scancode_dout, kbstatus_dout;
    logic       oe_n_scancode, oe_n_kbstatus, fifo_irq;

    int vectors = 0;
    int miscompares = 0;

    ps2_scancode_fifo #(.DEPTH(DEPTH), .AW(4), .IRQ_LEVEL(IRQ_LEVEL)) dut (
        .clk           (clk),
        .rst           (rst),
        .scan_received (scan_received),
        .scancode      (scancode),
        .extended      (extended),
        .released      (released),
        .ps2busy       (ps2busy),
        .kberror       (kberror),
        .zxuno_addr    (zxuno_addr),
        .zxuno_regrd   (zxuno_regrd),
        .zxuno_regwr   (zxuno_regwr),
        .din           (din),
        .scancode_dout (scancode_dout),
        .oe_n_scancode (oe_n_scancode),
        .kbstatus_dout (kbstatus_dout),
        .oe_n_kbstatus (oe_n_kbstatus),
        .fifo_irq      (fifo_irq)
    );

    always #5 clk = ~clk;

    // Reference model: contents as a queue of {rls, ext, code}.
    logic [9:0] q[$];
    logic m_ovf = 0, m_prev_sc = 0, m_prev_ks = 0, m_bsy = 0, m_err = 0, m_irq = 0;
    bit   model_valid = 0;

    always @(posedge clk) begin
        bit sc_now, ks_now, pop, flush, drop;
        if (rst) begin
            q.delete();
            m_ovf = 0; m_prev_sc = 0; m_prev_ks = 0; m_bsy = 0; m_err = 0; m_irq = 0;
            model_valid = 1;
        end else begin
            sc_now = zxuno_regrd && zxuno_addr == 8'h04;
            ks_now = zxuno_regrd && zxuno_addr == 8'h05;
            pop    = m_prev_sc && !sc_now && q.size() > 0;
            flush  = zxuno_regwr && zxuno_addr == 8'h05 && din[7];
            drop   = 0;
            m_irq  = (q.size() >= IRQ_LEVEL) || m_ovf;
            if (flush) begin
                q.delete();
                m_ovf = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (scan_received) begin
                    if (q.size() < DEPTH) q.push_back({released, extended, scancode});
                    else drop = 1;
                end
                if (drop) m_ovf = 1;
                else if (m_prev_ks && !ks_now) m_ovf = 0;
            end
            m_prev_sc = sc_now;
            m_prev_ks = ks_now;
            m_bsy = ps2busy;
            m_err = kberror;
        end
    end

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e_sc, e_ks;
        logic       e_irq;
        if (model_valid) begin
            e_sc = (q.size() > 0) ? q[0][7:0] : 8'h00;
            e_ks = {m_bsy, m_ovf, (q.size() == DEPTH), 1'b0, m_err,
                    (q.size() > 0) ? q[0][9] : 1'b0,
                    (q.size() > 0) ? q[0][8] : 1'b0,
                    (q.size() > 0)};
`ifdef PS2_FIFO_IRQ_EN
            e_irq = m_irq;
`else
            e_irq = 1'b0;
`endif
            cmp("scancode_dout", scancode_dout, e_sc);
            cmp("kbstatus_dout", kbstatus_dout, e_ks);
            cmp("oe_n_scancode", {7'd0, oe_n_scancode},
                {7'd0, !(zxuno_regrd && zxuno_addr == 8'h04)});
            cmp("oe_n_kbstatus", {7'd0, oe_n_kbstatus},
                {7'd0, !(zxuno_regrd && zxuno_addr == 8'h05)});
            cmp("fifo_irq", {7'd0, fifo_irq}, {7'd0, e_irq});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] code, input logic ext, input logic rls);
        scan_received = 1; scancode = code; extended = ext; released = rls;
        step();
        scan_received = 0;
    endtask

    task automatic read_sc(output logic [7:0] data);
        data = scancode_dout;
        zxuno_addr = 8'h04; zxuno_regrd = 1;
        step(); step();
        zxuno_regrd = 0;
        step();
    endtask

    task automatic read_ks(output logic [7:0] data);
        data = kbstatus_dout;
        zxuno_addr = 8'h05; zxuno_regrd = 1;
        step(); step();
        zxuno_regrd = 0;
        step();
    endtask

    initial begin
        logic [7:0] d;
        step(); step();
        rst = 0;
        cmp("reset_ks", kbstatus_dout, 8'h00);
        cmp("reset_sc", scancode_dout, 8'h00);

        // Single key
        push(8'h1C, 0, 0);
        cmp("single_pen", kbstatus_dout, 8'h01);
        cmp("single_code", scancode_dout, 8'h1C);
        read_sc(d);
        cmp("single_read", d, 8'h1C);
        cmp("single_empty", kbstatus_dout, 8'h00);

        // Ordering with flags
        push(8'h1C, 0, 0); push(8'h75, 1, 0); push(8'h1C, 0, 1);
        read_ks(d); cmp("ord_ks1", d, 8'h01);
        read_sc(d); cmp("ord_sc1", d, 8'h1C);
        read_ks(d); cmp("ord_ks2", d, 8'h03);
        read_sc(d); cmp("ord_sc2", d, 8'h75);
        read_ks(d); cmp("ord_ks3", d, 8'h05);
        read_sc(d); cmp("ord_sc3", d, 8'h1C);

        // Overflow
        for (int i = 1; i <= 17; i++) push(8'(i), 0, 0);
        cmp("ovf_status", kbstatus_dout, 8'h61);
        for (int i = 1; i <= 16; i++) begin
            read_sc(d);
            cmp("ovf_read", d, 8'(i));
        end
        cmp("ovf_empty_sticky", kbstatus_dout, 8'h40);
        read_ks(d);
        cmp("ovf_cleared", kbstatus_dout, 8'h00);

        // Simultaneous push and pop while full
        for (int i = 1; i <= 16; i++) push(8'(i), 0, 0);
        zxuno_addr = 8'h04; zxuno_regrd = 1;
        step();
        zxuno_regrd = 0;
        push(8'h22, 0, 0);
        cmp("simul_status", kbstatus_dout, 8'h21);
        for (int i = 2; i <= 16; i++) read_sc(d);
        read_sc(d);
        cmp("simul_last", d, 8'h22);

        // Flush
        for (int i = 0; i < 5; i++) push(8'h30 + 8'(i), 0, 0);
        zxuno_addr = 8'h05; din = 8'h80; zxuno_regwr = 1;
        step();
        zxuno_regwr = 0; din = 8'h00;
        cmp("flush_ks", kbstatus_dout, 8'h00);
        cmp("flush_sc", scancode_dout, 8'h00);

        // Reset during a read
        push(8'h41, 0, 0); push(8'h42, 0, 0);
        zxuno_addr = 8'h04; zxuno_regrd = 1;
        step();
        rst = 1;
        step();
        zxuno_regrd = 0;
        step();
        rst = 0;
        step();
        cmp("rst_ks", kbstatus_dout, 8'h00);
        cmp("rst_sc", scancode_dout, 8'h00);
        cmp("rst_irq", {7'd0, fifo_irq}, 8'h00);

        // Randomised traffic against the model
        for (int c = 0; c < 4000; c++) begin
            scan_received = ($urandom_range(0, 99) < 45);
            scancode      = 8'($urandom);
            extended      = 1'($urandom);
            released      = 1'($urandom);
            ps2busy       = 1'($urandom);
            kberror       = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0, 1, 2: zxuno_addr = 8'h04;
                3, 4:    zxuno_addr = 8'h05;
                default: zxuno_addr = 8'($urandom);
            endcase
            zxuno_regrd   = ($urandom_range(0, 99) < 40);
            zxuno_regwr   = ($urandom_range(0, 99) < 2);
            din           = 8'($urandom);
            rst           = ($urandom_range(0, 999) == 0);
            step();
        end
        scan_received = 0; zxuno_regrd = 0; zxuno_regwr = 0; rst = 0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
